// File: rtl/bg_draw_pkg.sv
// Shared types and colour constants for the background pattern generator.
// Colours are packed RRRGGGBB.
`timescale 1ns/1ps
package bg_draw_pkg;

  typedef enum logic [1:0] {
    SOLID   = 2'd0,
    BORDER  = 2'd1,
    MATRIX  = 2'd2,
    CHECKER = 2'd3
  } bg_mode_t;

  localparam logic [7:0] COLOR_WHITE  = 8'hFF;
  localparam logic [7:0] COLOR_BORDER = 8'hFC;
  localparam logic [7:0] COLOR_BLACK  = 8'h00;

  // The colour matrix is always 16x16 tiles, so row/col each fit a nibble.
  localparam int MATRIX_TILES = 16;

  function automatic bg_mode_t next_mode(input bg_mode_t m);
    return bg_mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/bg_match_counter.sv
// Counts active pixels equal to MATCH_COLOR per frame and latches the
// previous frame's total at each frame start.
`timescale 1ns/1ps
module bg_match_counter #(
  parameter logic [7:0] MATCH_COLOR = 8'hE0,
  parameter int         COUNT_W     = 19
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [7:0]         mif_vga,
  input  logic               active,
  input  logic               frame_start,
  output logic               isMatch,
  output logic [COUNT_W-1:0] matchCount
);

  logic               hit;
  logic               count_hit;
  logic [COUNT_W-1:0] count_q;

  assign hit       = (mif_vga == MATCH_COLOR);
  assign count_hit = hit && active;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      isMatch    <= 1'b0;
      matchCount <= '0;
      count_q    <= '0;
    end else begin
      isMatch <= hit;
      if (frame_start) begin
        // The frame-start pixel belongs to the new frame.
        matchCount <= count_q;
        count_q    <= COUNT_W'(count_hit);
      end else if (count_hit && (count_q != '1)) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/back_ground_pattern_gen.sv
// Background pattern generator: solid, border, colour-matrix and checker
// patterns, one-cycle registered, with a per-frame match counter.
`timescale 1ns/1ps
module back_ground_pattern_gen
  import bg_draw_pkg::*;
#(
  parameter int         FRAME_W       = 640,
  parameter int         FRAME_H       = 480,
  parameter int         BORDER_OFFSET = 30,
  parameter int         TILE_LOG2     = 3,
  parameter int         MATRIX_LEFT_X = 100,
  parameter int         MATRIX_TOP_Y  = 100,
  parameter logic [7:0] MATCH_COLOR   = 8'hE0,
  parameter int         COUNT_W       = 19
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic [7:0]         mif_vga,
  input  logic               modeStep,
  output logic [7:0]         BG_RGB,
  output logic               boardersDrawReq,
  output logic               isMatch,
  output logic [COUNT_W-1:0] matchCount,
  output logic [1:0]         mode
);

  localparam logic [10:0] FRAME_W_C  = 11'(FRAME_W);
  localparam logic [10:0] FRAME_H_C  = 11'(FRAME_H);
  localparam logic [10:0] BORDER_L   = 11'(BORDER_OFFSET);
  localparam logic [10:0] BORDER_R   = 11'(FRAME_W - 1 - BORDER_OFFSET);
  localparam logic [10:0] BORDER_B   = 11'(FRAME_H - 1 - BORDER_OFFSET);
  localparam logic [10:0] MX_LEFT    = 11'(MATRIX_LEFT_X);
  localparam logic [10:0] MX_TOP     = 11'(MATRIX_TOP_Y);
  localparam logic [10:0] MX_SPAN    = 11'(MATRIX_TILES << TILE_LOG2);

  bg_mode_t    mode_q, mode_d;
  logic        pending_q, pending_d;
  logic        was_origin;
  logic        at_origin, frame_start, active;
  logic        on_border, in_matrix, checker_odd;
  logic [10:0] dx, dy;
  logic [7:0]  rgb_d;
  logic        draw_d;

  assign at_origin = (pixelX == 11'd0) && (pixelY == 11'd0);
  // A held (0,0) is a single frame start: only the entry into it counts.
  assign frame_start = at_origin && !was_origin;
  assign active      = (pixelX < FRAME_W_C) && (pixelY < FRAME_H_C);

  assign on_border = (pixelX == BORDER_L) || (pixelY == BORDER_L) ||
                     (pixelX == BORDER_R) || (pixelY == BORDER_B);

  assign dx        = pixelX - MX_LEFT;
  assign dy        = pixelY - MX_TOP;
  assign in_matrix = (pixelX >= MX_LEFT) && (dx < MX_SPAN) &&
                     (pixelY >= MX_TOP)  && (dy < MX_SPAN);

  // Parity of (x>>T)+(y>>T) is the XOR of the two tile-index LSBs.
  assign checker_odd = pixelX[TILE_LOG2] ^ pixelY[TILE_LOG2];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pending_d = pending_q | modeStep;
    mode_d    = mode_q;
    if (frame_start && pending_d) begin
      mode_d    = next_mode(mode_q);
      pending_d = 1'b0;
    end
  end

  // Rendered in mode_d so the frame-start pixel already uses the new mode.
  always_comb begin
    rgb_d  = COLOR_BLACK;
    draw_d = 1'b0;
    if (active) begin
      rgb_d = COLOR_WHITE;
      case (mode_d)
        BORDER: begin
          if (on_border) begin
            rgb_d  = COLOR_BORDER;
            draw_d = 1'b1;
          end
        end
        MATRIX: begin
          if (in_matrix) begin
            rgb_d  = {dy[TILE_LOG2 +: 4], dx[TILE_LOG2 +: 4]};
            draw_d = 1'b1;
          end
        end
        CHECKER: begin
          if (checker_odd) rgb_d = COLOR_BLACK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      mode_q          <= SOLID;
      pending_q       <= 1'b0;
      was_origin      <= 1'b0;
      BG_RGB          <= COLOR_BLACK;
      boardersDrawReq <= 1'b0;
    end else begin
      mode_q          <= mode_d;
      pending_q       <= pending_d;
      was_origin      <= at_origin;
      BG_RGB          <= rgb_d;
      boardersDrawReq <= draw_d;
    end
  end

  assign mode = mode_q;

  bg_match_counter #(
    .MATCH_COLOR (MATCH_COLOR),
    .COUNT_W     (COUNT_W)
  ) u_match_counter (
    .clk         (clk),
    .resetN      (resetN),
    .mif_vga     (mif_vga),
    .active      (active),
    .frame_start (frame_start),
    .isMatch     (isMatch),
    .matchCount  (matchCount)
  );

endmodule

// File: doc/back_ground_pattern_gen.md
BACK_GROUND_PATTERN_GEN -- requirements
Module: back_ground_pattern_gen

Interface
REQ-001 SHALL have parameter FRAME_W, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter BORDER_OFFSET, default 30, meaning distance of the border lines from the frame edges.
REQ-004 SHALL have parameter TILE_LOG2, default 3, meaning log2 of the matrix/checker tile edge in pixels.
REQ-005 SHALL have parameter MATRIX_LEFT_X and MATRIX_TOP_Y, default 100/100, meaning the color-matrix origin.
REQ-006 SHALL have parameter MATCH_COLOR, default 8'hE0, meaning the mif_vga value to detect.
REQ-007 SHALL have parameter COUNT_W, default 19, meaning the match-counter width.
REQ-008 SHALL have port clk, input, 1, the system clock; the block uses this single clock only.
REQ-009 SHALL have port resetN, input, 1, reset: synchronous, active-low.
REQ-010 SHALL have port pixelX, input, 11, the current pixel column.
REQ-011 SHALL have port pixelY, input, 11, the current pixel line.
REQ-012 SHALL have port mif_vga, input, 8, the bitmap pixel under test.
REQ-013 SHALL have port modeStep, input, 1, a one-cycle request to advance the mode.
REQ-014 SHALL have port BG_RGB, output, 8, the background color as RRRGGGBB.
REQ-015 SHALL have port boardersDrawReq, output, 1, asserted while a border or matrix pixel is drawn.
REQ-016 SHALL have port isMatch, output, 1, high when mif_vga equals MATCH_COLOR.
REQ-017 SHALL have port matchCount, output, COUNT_W, the match total of the previous frame.
REQ-018 SHALL have port mode, output, 2, the current pattern mode.

Function
REQ-019 All outputs SHALL be registered, with exactly 1 clk latency from pixelX/pixelY/mif_vga.
REQ-020 Mode SOLID(0) SHALL output BG_RGB=8'hFF and boardersDrawReq=0.
REQ-021 Mode BORDER(1) SHALL output 8'hFF except where x==OFF, y==OFF, x==FRAME_W-1-OFF or y==FRAME_H-1-OFF; there it SHALL output 8'hFC with boardersDrawReq=1.
REQ-022 Mode MATRIX(2) covers a 16x16-tile region at the matrix origin; inside it, col=(x-LEFT)>>TILE_LOG2 and row=(y-TOP)>>TILE_LOG2, BG_RGB={row[3:0],col[3:0]} and boardersDrawReq=1; outside it, SOLID behaviour applies.
REQ-023 Mode CHECKER(3) SHALL output 8'h00 when ((x>>TILE_LOG2)+(y>>TILE_LOG2)) is odd and 8'hFF otherwise, with boardersDrawReq=0.
REQ-024 Pixels with x>=FRAME_W or y>=FRAME_H SHALL output BG_RGB=8'h00 and boardersDrawReq=0 in every mode.
REQ-025 modeStep SHALL set a pending flag; repeated pulses before the flag is consumed SHALL count once.
REQ-026 At frame start (pixelX==0 && pixelY==0), a set pending flag SHALL advance mode by 1 mod 4 and clear the flag.
REQ-027 A modeStep in the same cycle as frame start SHALL be applied at that frame start.
REQ-028 The frame start cycle SHALL be rendered in the new mode.
REQ-029 The frame counter SHALL increment on each active pixel with mif_vga==MATCH_COLOR, saturating at all-ones.
REQ-030 At frame start, matchCount SHALL load the counter value and the counter SHALL restart at 1 if that pixel matches, else 0.
REQ-031 A frame start that is held for several cycles (same coordinates) SHALL be treated as one event, detected on the coordinate change into (0,0).

Reset
REQ-032 While resetN==0 at a clk edge, BG_RGB, boardersDrawReq, isMatch, matchCount, mode, the pending flag and the counter SHALL all be cleared to 0.
REQ-033 After reset mid-frame, the first matchCount SHALL report the partial frame; no other recovery SHALL occur.

Structure
REQ-034 Package bg_draw_pkg SHALL hold the mode enum (SOLID, BORDER, MATRIX, CHECKER) and the color constants 8'hFF, 8'hFC and 8'h00.
REQ-035 Sub-module bg_match_counter SHALL hold the compare, saturating counter and frame latch (REQ-029..031).

Verification
REQ-036 Reset held, any inputs -> all outputs 0, mode=0.
REQ-037 Mode 1, pixel (30,200) -> next clk BG_RGB=8'hFC and boardersDrawReq=1; pixel (31,200) -> BG_RGB=8'hFF.
REQ-038 Three modeStep pulses in one frame -> mode increments by exactly 1 at the next (0,0); a modeStep at (0,0) itself -> applied on that cycle.
REQ-039 Mode 2, pixel (100+8*5, 100+8*3) -> BG_RGB=8'h35; pixel (99,100) -> 8'hFF.
REQ-040 Frame containing 1000 pixels with mif_vga=8'hE0 -> matchCount=1000 after the next (0,0); COUNT_W=4 with 20 matches -> matchCount=15.
